// File: rtl/run_controller_pkg.sv
// Shared types for the run controller: FSM state encoding (doubles as the LED code)
// and the clock-enable divider width.
package run_controller_pkg;

    localparam int unsigned DIV_W = 16;

    typedef enum logic [1:0] {
        PAUSE  = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } rc_state_t;

endpackage

// File: rtl/run_controller_button.sv
// Button conditioning: 2-flop synchroniser, stability counter debounce and a
// one-cycle press pulse on the debounced rising edge (releases give no pulse).
module button_debounce #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db;
    logic             db_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            press <= db & ~db_q;
            // Flip only after DB_CYCLES consecutive cycles of disagreement.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/pause/step/halt sequencer for the 8-bit Machine: debounced buttons drive an
// FSM that issues registered cpu_ce strobes from a clock-enable divider.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CE_DIV    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic       halt_req,
    output logic       cpu_ce,
    output logic       cpu_clear,
    output logic       running,
    output logic       halted,
    output logic [1:0] led_state
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic             start_p;
    logic             step_p;
    rc_state_t        state;
    rc_state_t        state_n;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic             ce_n;
    logic             clr_n;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk   (clk),
        .reset (reset),
        .raw   (start),
        .press (start_p)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk   (clk),
        .reset (reset),
        .raw   (step),
        .press (step_p)
    );

    // cpu_ce is registered, so it is computed one cycle ahead and lines up with
    // the state register; halt_req is judged against the strobe actually issued.
    always_comb begin
        state_n = state;
        div_n   = div;
        ce_n    = 1'b0;
        clr_n   = 1'b0;
        case (state)
            PAUSE: begin
                div_n = '0;
                if (start_p) begin
                    state_n = RUN;
                end else if (step_p) begin
                    state_n = STEP;
                    ce_n    = 1'b1;
                end
            end
            RUN: begin
                if (cpu_ce && halt_req) begin
                    state_n = HALTED;
                    div_n   = '0;
                end else if (start_p) begin
                    state_n = PAUSE;
                    div_n   = '0;
                end else if (div == DIV_LAST) begin
                    div_n = '0;
                    ce_n  = 1'b1;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            STEP: begin
                div_n   = '0;
                state_n = (cpu_ce && halt_req) ? HALTED : PAUSE;
            end
            HALTED: begin
                div_n = '0;
                if (start_p) begin
                    state_n = PAUSE;
                    clr_n   = 1'b1;
                end
            end
            default: begin
                state_n = PAUSE;
                div_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PAUSE;
            div       <= '0;
            cpu_ce    <= 1'b0;
            cpu_clear <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            cpu_ce    <= ce_n;
            cpu_clear <= clr_n;
        end
    end

    assign running   = (state == RUN);
    assign halted    = (state == HALTED);
    assign led_state = state;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with DB_CYCLES=4, CE_DIV=3: press latency,
// glitch rejection, stepping, halt, clear and reset behaviour.
module tb_run_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       step;
    logic       halt_req;
    logic       cpu_ce;
    logic       cpu_clear;
    logic       running;
    logic       halted;
    logic [1:0] led_state;

    int checks   = 0;
    int failures = 0;

    run_controller #(.DB_CYCLES(4), .CE_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step      (step),
        .halt_req  (halt_req),
        .cpu_ce    (cpu_ce),
        .cpu_clear (cpu_clear),
        .running   (running),
        .halted    (halted),
        .led_state (led_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a press of either button for 12 cycles, then release and let it settle.
    task automatic press_idle(input logic s, input logic t);
        start = s;
        step  = t;
        for (int i = 0; i < 12; i++) tick();
        start = 1'b0;
        step  = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({cpu_ce, cpu_clear, running, halted, led_state} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {cpu_ce, cpu_clear, running, halted, led_state});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (led_state !== 2'b00 || cpu_ce !== 1'b0) begin
            failures++;
            $display("FAIL after_reset led=%b ce=%b exp led=00 ce=0", led_state, cpu_ce);
        end
    endtask

    task automatic test_start_run();
        logic exp_run;
        logic exp_ce;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_run = (k >= 8);
            exp_ce  = (k >= 11) && (((k - 11) % 3) == 0);
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL start_running k=%0d got=%b exp=%b", k, running, exp_run);
            end
            checks++;
            if (cpu_ce !== exp_ce) begin
                failures++;
                $display("FAIL run_ce k=%0d got=%b exp=%b", k, cpu_ce, exp_ce);
            end
            if (k == 8) begin
                checks++;
                if (led_state !== 2'b01) begin
                    failures++;
                    $display("FAIL run_led got=%b exp=01", led_state);
                end
            end
            if (k == 20) start = 1'b0;
        end
        press_idle(1'b1, 1'b0);
        checks++;
        if (led_state !== 2'b00) begin
            failures++;
            $display("FAIL run_to_pause got=%b exp=00", led_state);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 30; i++) begin
            start = ((i % 3) != 2);
            tick();
            checks++;
            if (cpu_ce !== 1'b0 || led_state !== 2'b00) begin
                failures++;
                $display("FAIL glitch i=%0d ce=%b led=%b exp ce=0 led=00", i, cpu_ce, led_state);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (cpu_ce !== 1'b0 || led_state !== 2'b00) begin
                failures++;
                $display("FAIL glitch_release i=%0d ce=%b led=%b exp ce=0 led=00", i, cpu_ce, led_state);
            end
        end
    endtask

    task automatic test_step();
        int   ce_count;
        logic [1:0] exp_led;
        for (int p = 0; p < 2; p++) begin
            ce_count = 0;
            step = 1'b1;
            for (int k = 1; k <= 24; k++) begin
                tick();
                if (cpu_ce === 1'b1) ce_count++;
                exp_led = (k == 8) ? 2'b10 : 2'b00;
                checks++;
                if (led_state !== exp_led || cpu_ce !== (k == 8)) begin
                    failures++;
                    $display("FAIL step p=%0d k=%0d led=%b ce=%b exp led=%b ce=%b",
                             p, k, led_state, cpu_ce, exp_led, (k == 8));
                end
                if (k == 12) step = 1'b0;
            end
            checks++;
            if (ce_count != 1) begin
                failures++;
                $display("FAIL step_count p=%0d got=%0d exp=1", p, ce_count);
            end
        end
    endtask

    task automatic test_halt();
        int ce_count;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 12) begin
                start    = 1'b0;
                halt_req = 1'b1;
            end
            if (k == 12 || k == 13) begin
                checks++;
                if (running !== 1'b1 || halted !== 1'b0 || cpu_ce !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_wait k=%0d run=%b halt=%b ce=%b exp 1 0 0",
                             k, running, halted, cpu_ce);
                end
            end
            if (k == 14) begin
                checks++;
                if (cpu_ce !== 1'b1 || running !== 1'b1) begin
                    failures++;
                    $display("FAIL halt_strobe ce=%b run=%b exp 1 1", cpu_ce, running);
                end
            end
            if (k == 15) begin
                checks++;
                if (halted !== 1'b1 || led_state !== 2'b11 || cpu_ce !== 1'b0 || running !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_enter halt=%b led=%b ce=%b run=%b exp 1 11 0 0",
                             halted, led_state, cpu_ce, running);
                end
            end
        end
        halt_req = 1'b0;
        ce_count = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cpu_ce === 1'b1) ce_count++;
        end
        checks++;
        if (ce_count != 0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_quiet ce_count=%0d halt=%b exp 0 1", ce_count, halted);
        end
    endtask

    task automatic test_clear();
        int clr_count;
        step = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 12) step = 1'b0;
            checks++;
            if (halted !== 1'b1 || cpu_ce !== 1'b0 || cpu_clear !== 1'b0) begin
                failures++;
                $display("FAIL halted_step k=%0d halt=%b ce=%b clr=%b exp 1 0 0",
                         k, halted, cpu_ce, cpu_clear);
            end
        end
        clr_count = 0;
        start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 12) start = 1'b0;
            if (cpu_clear === 1'b1) clr_count++;
            if (k == 7 || k == 8 || k == 9) begin
                checks++;
                if (cpu_clear !== (k == 8) || halted !== (k == 7) || cpu_ce !== 1'b0) begin
                    failures++;
                    $display("FAIL clear k=%0d clr=%b halt=%b ce=%b exp %b %b 0",
                             k, cpu_clear, halted, cpu_ce, (k == 8), (k == 7));
                end
            end
        end
        checks++;
        if (clr_count != 1 || led_state !== 2'b00) begin
            failures++;
            $display("FAIL clear_count got=%0d led=%b exp 1 00", clr_count, led_state);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        press_idle(1'b1, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL resume_run got=%b exp=1", running);
        end
        start = 1'b1;
        step  = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 12) begin
                start = 1'b0;
                step  = 1'b0;
            end
            checks++;
            if (led_state === 2'b10) begin
                failures++;
                $display("FAIL both_no_step k=%0d led=%b exp not 10", k, led_state);
            end
            if (k >= 8) begin
                checks++;
                if (led_state !== 2'b00 || cpu_ce !== 1'b0) begin
                    failures++;
                    $display("FAIL both_pause k=%0d led=%b ce=%b exp 00 0", k, led_state, cpu_ce);
                end
            end
        end
        press_idle(1'b1, 1'b0);
        start = 1'b1;
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_ce, cpu_clear, running, halted, led_state} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=000000",
                     {cpu_ce, cpu_clear, running, halted, led_state});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cpu_ce, cpu_clear, running, halted, led_state} !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=%b exp=000000", i,
                         {cpu_ce, cpu_clear, running, halted, led_state});
            end
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (led_state !== 2'b00 || cpu_ce !== 1'b0) begin
                failures++;
                $display("FAIL post_reset i=%0d led=%b ce=%b exp 00 0", i, led_state, cpu_ce);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_glitch();
        test_step();
        test_halt();
        test_clear();
        test_simultaneous_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences execution of the 8-bit Machine from the on-board oscillator domain, replacing free-running clock gating with a clock-enable scheduler.
- Debounces the start and step buttons and runs a RUN / PAUSE / STEP / HALTED state machine.
- Emits a one-cycle `cpu_ce` strobe per machine cycle, plus a machine-clear pulse and status LEDs.
- Sits in top between the oscillator and Machine. Machine clocks on `clk` and advances only when `cpu_ce` is high.

Parameters:
- DB_CYCLES, 50000: consecutive stable cycles required before a debounced button changes (about 8 ms at 6 MHz).
- CE_DIV, 6: in RUN, one `cpu_ce` per CE_DIV clk cycles. Legal range is 1..65535.

Ports:
- clk  input  1  system clock (oscillator output).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw start/pause button, active-high, asynchronous to clk.
- step  input  1  raw single-step button, active-high, asynchronous to clk.
- halt_req  input  1  Machine executed HLT; level, synchronous to clk.
- cpu_ce  output  1  machine clock enable, one-cycle strobe.
- cpu_clear  output  1  one-cycle synchronous clear to Machine.
- running  output  1  high in RUN.
- halted  output  1  high in HALTED.
- led_state  output  2  state encoding for LEDs: PAUSE=00, RUN=01, STEP=10, HALTED=11.

Behaviour:
- Reset (reset=0, async):
  - state=PAUSE; `cpu_ce`=0, `cpu_clear`=0, `running`=0, `halted`=0, `led_state`=00.
  - Debouncers cleared to released; divider=0.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: restarts whenever the synced input equals the current debounced value. The debounced value flips when the synced input has differed for DB_CYCLES consecutive cycles.
  - Rising-edge detect on the debounced value produces a one-cycle press pulse.
  - Press latency from a clean raw edge: 2 + DB_CYCLES + 1 cycles. A release produces no pulse.
- Simultaneous start and step press in the same cycle: start wins, step is dropped.
- FSM transitions:
  - PAUSE:
    - start press → RUN, divider cleared to 0.
    - step press → STEP.
  - RUN:
    - Divider counts 0..CE_DIV-1; `cpu_ce`=1 in the cycle divider==CE_DIV-1, then the divider wraps to 0.
    - First `cpu_ce` occurs CE_DIV cycles after entry. CE_DIV=1 gives `cpu_ce` every cycle.
    - start press → PAUSE; a `cpu_ce` due in that same cycle is suppressed.
    - step press is ignored.
  - STEP:
    - `cpu_ce`=1 for exactly the first cycle in STEP, then → PAUSE.
    - Button presses in STEP are ignored.
  - halt_req:
    - Sampled only in a cycle where `cpu_ce`=1; that cycle's `cpu_ce` still issues.
    - Next state is HALTED, taking priority over the RUN→PAUSE and STEP→PAUSE transitions.
    - halt_req while `cpu_ce`=0 is ignored.
  - HALTED:
    - `cpu_ce`=0.
    - step press is ignored.
    - start press → PAUSE with `cpu_clear`=1 for exactly one cycle (the first PAUSE cycle).
- Outputs are registered. `running`, `halted` and `led_state` are decoded from the state register.
- `cpu_ce` is never high in PAUSE or HALTED, and never high for 2 consecutive cycles unless CE_DIV=1.
- Reset mid-RUN or mid-debounce aborts immediately with no strobe glitch; all outputs are 0 while reset=0.
- Divider width 16 bits; debounce counter width $clog2(DB_CYCLES+1).

Decomposition:
- Package run_controller_pkg:
  - state enum `rc_state_t` (PAUSE, RUN, STEP, HALTED) with the `led_state` encodings above.
  - Constant for the divider width.
- Sub-module button_debounce (synchroniser + counter + edge pulse, parameter DB_CYCLES), instantiated twice.
- FSM and divider live in run_controller.

Test Plan (DB_CYCLES=4, CE_DIV=3):
1. Reset, then a clean start press held 20 cycles → press pulse 7 cycles after the raw edge, `running`=1, `cpu_ce` pulses every 3rd cycle starting 3 cycles after entering RUN.
2. Start held high with 1-cycle low glitches every 3 cycles, then released → no press pulse, state stays PAUSE, `cpu_ce` never asserted.
3. From PAUSE, step press → exactly one `cpu_ce` cycle, `led_state` 00→10→00. A second step press gives exactly one more.
4. RUN with halt_req raised between strobes → state unchanged until the next `cpu_ce`, which issues; then `halted`=1, `led_state`=11, no further `cpu_ce` over 50 cycles.
5. In HALTED: step press → no change. start press → `cpu_clear` high for exactly one cycle, state PAUSE, `halted`=0.
6. RUN with start and step pressed in the same cycle → PAUSE, no STEP strobe. Separately, reset=0 asserted mid-RUN → all outputs 0 asynchronously, PAUSE after release.
